pc_sequencer: RTL

Parametrised program-counter sequencer for the instruction-fetch stage. It holds the fetch address and selects the next PC from several sources: sequential increment, branch target, jump target, or return. It supports pipeline stall and an optional hardware return-address stack (RAS). It replaces the plain PC register at the front of the datapath and drives instruction-memory address and the PC+INCR value forwarded to decode.

---
 rtl/pc_sequencer_if.sv | 34 +++
 rtl/pc_sequencer.sv | 124 ++++++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: bundle between the fetch-control logic (master) and the
// program-counter sequencer (slave).
//   master drives Stall, BranchTaken/BranchTarget, Jump/Link/JumpTarget,
//          Return/ReturnTarget, and observes PCResult, PCPlusInc,
//          RasEmpty, RasFull.
//   slave  is the sequencer side: the same signals with directions reversed.
interface pc_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             Stall;
  logic             BranchTaken;
  logic [WIDTH-1:0] BranchTarget;
  logic             Jump;
  logic             Link;
  logic [WIDTH-1:0] JumpTarget;
  logic             Return;
  logic [WIDTH-1:0] ReturnTarget;
  logic [WIDTH-1:0] PCResult;
  logic [WIDTH-1:0] PCPlusInc;
  logic             RasEmpty;
  logic             RasFull;

  modport master (
    output Stall, BranchTaken, BranchTarget, Jump, Link, JumpTarget,
           Return, ReturnTarget,
    input  PCResult, PCPlusInc, RasEmpty, RasFull
  );

  modport slave (
    input  Stall, BranchTaken, BranchTarget, Jump, Link, JumpTarget,
           Return, ReturnTarget,
    output PCResult, PCPlusInc, RasEmpty, RasFull
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with next-PC selection among
// sequential increment, branch, jump and return, plus stall and an optional
// return-address stack (RAS).
//
// Optional feature macro: PC_RAS_EN. When defined, a circular RAS of
// RAS_DEPTH entries is built; calls (Jump+Link) push PCPlusInc and Return
// pops it. When undefined, Return always uses the aligned ReturnTarget,
// Link has no effect, RasEmpty is tied 1 and RasFull tied 0.
//
// Ports:
//   Clk    clock, all state changes on the rising edge
//   Reset  synchronous active-high reset (PC <- RESET_VECTOR, RAS emptied)
//   bus    pc_sequencer_if.slave: redirect/stall controls in,
//          PCResult / PCPlusInc / RasEmpty / RasFull out
module pc_sequencer #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               INCR         = 4,
  parameter int               ALIGN_BITS   = 2,
  parameter int               RAS_DEPTH    = 4
) (
  input logic           Clk,
  input logic           Reset,
  pc_sequencer_if.slave bus
);

  localparam logic [WIDTH-1:0] ALIGN_MASK =
    ~((WIDTH'(1) << ALIGN_BITS) - WIDTH'(1));

  function automatic logic [WIDTH-1:0] align_addr(input logic [WIDTH-1:0] a);
    return a & ALIGN_MASK;
  endfunction

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc_plus;
  logic             ras_hit;   // Return can be served from the stack
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty;
  logic             ras_full;

  // Wraps modulo 2^WIDTH by construction.
  assign pc_plus = pc_q + WIDTH'(INCR);

  always_comb begin
    pc_d = pc_plus;
    if (bus.Stall) begin
      pc_d = pc_q;
    end else if (bus.Return) begin
      if (ras_hit) pc_d = ras_top;
      else         pc_d = align_addr(bus.ReturnTarget);
    end else if (bus.Jump) begin
      pc_d = align_addr(bus.JumpTarget);
    end else if (bus.BranchTaken) begin
      pc_d = align_addr(bus.BranchTarget);
    end
  end

  // ---- fetch-address register ----
  always_ff @(posedge Clk) begin
    if (Reset) pc_q <= RESET_VECTOR;
    else       pc_q <= pc_d;
  end

`ifdef PC_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RAS_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    return (p == '0) ? PW'(RAS_DEPTH - 1) : p - PW'(1);
  endfunction

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    top_q;   // index of the most recent entry
  logic [CW-1:0]    cnt_q;   // saturating occupancy 0..RAS_DEPTH
  logic             do_push;
  logic             do_pop;

  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CW'(RAS_DEPTH));
  assign ras_hit   = ~ras_empty;
  assign ras_top   = ras_mem[top_q];

  // Return outranks Jump, so a Return+Jump+Link cycle never pushes.
  assign do_pop  = ~bus.Stall & bus.Return & ~ras_empty;
  assign do_push = ~bus.Stall & ~bus.Return & bus.Jump & bus.Link;

  // ---- RAS control ----
  // When full, top+1 lands on the oldest entry, so a push overwrites it
  // while the count stays saturated.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      top_q <= '0;
      cnt_q <= '0;
    end else if (do_push) begin
      top_q <= ptr_inc(top_q);
      if (!ras_full) cnt_q <= cnt_q + CW'(1);
    end else if (do_pop) begin
      top_q <= ptr_dec(top_q);
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // ---- RAS storage (contents are don't-care after reset) ----
  always_ff @(posedge Clk) begin
    if (do_push) ras_mem[ptr_inc(top_q)] <= pc_plus;
  end
`else
  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
  assign ras_hit   = 1'b0;
  assign ras_top   = '0;
`endif

  assign bus.PCResult  = pc_q;
  assign bus.PCPlusInc = pc_plus;
  assign bus.RasEmpty  = ras_empty;
  assign bus.RasFull   = ras_full;

endmodule
